// File: rtl/ysyx_220053_alu_pkg.sv
// Shared constants and stage-register layout for the npc integer adder family.
// Imported by the pipelined adder/subtractor and its carry-lookahead slice.
package ysyx_220053_alu_pkg;

    localparam int ADDSUB_WIDTH  = 64;
    localparam int ADDSUB_STAGES = 4;
    localparam int ADDSUB_TAG_W  = 5;
    localparam int ADDSUB_CW     = ADDSUB_WIDTH / ADDSUB_STAGES;

    // Per-stage control word; the tag lives beside it because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
        logic zero;
        logic x_sign;
        logic y_sign;
        logic ovf;
    } addsub_stage_t;

    function automatic int addsub_cw(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/ysyx_220053_cla_slice.sv
// CW-bit carry-lookahead slice: Kogge-Stone group generate/propagate prefix,
// producing the slice sum, its carry out and a slice-is-zero flag.
module ysyx_220053_cla_slice #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          zero
);

    logic [CW-1:0] w_half;
    logic [CW-1:0] w_g;
    logic [CW-1:0] w_p;
    logic [CW-1:0] w_g_prev;
    logic [CW-1:0] w_p_prev;
    logic [CW:0]   w_c;

    always_comb begin
        w_half   = a ^ b;
        w_g      = a & b;
        w_p      = a ^ b;
        w_g_prev = '0;
        w_p_prev = '0;
        // After the last level, w_g[i]/w_p[i] span bits 0..i.
        for (int l = 1; l < CW; l = l * 2) begin
            w_g_prev = w_g;
            w_p_prev = w_p;
            for (int i = l; i < CW; i++) begin
                w_g[i] = w_g_prev[i] | (w_p_prev[i] & w_g_prev[i-l]);
                w_p[i] = w_p_prev[i] & w_p_prev[i-l];
            end
        end
        w_c = {w_g | (w_p & {CW{cin}}), cin};
    end

    assign s    = w_half ^ w_c[CW-1:0];
    assign cout = w_c[CW];
    assign zero = ~|s;

endmodule

// File: rtl/ysyx_220053_pipe_addsub.sv
// Pipelined CLA adder/subtractor with valid/ready flow control; slice k resolves in stage k.
// Optional synchronous pipeline flush port enabled by YSYX_220053_ADDSUB_FLUSH_EN.
module ysyx_220053_pipe_addsub
    import ysyx_220053_alu_pkg::*;
#(
    parameter int WIDTH  = ADDSUB_WIDTH,
    parameter int STAGES = ADDSUB_STAGES,
    parameter int TAG_W  = ADDSUB_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef YSYX_220053_ADDSUB_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = addsub_cw(WIDTH, STAGES);

    // r_data holds finished result slices below and still-unconsumed x slices above.
    addsub_stage_t     r_ctl  [STAGES];
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [WIDTH-1:0]  r_y    [STAGES];
    logic [TAG_W-1:0]  r_tag  [STAGES];

    addsub_stage_t     w_src_ctl  [STAGES];
    logic [WIDTH-1:0]  w_src_data [STAGES];
    logic [WIDTH-1:0]  w_src_y    [STAGES];
    logic [TAG_W-1:0]  w_src_tag  [STAGES];
    addsub_stage_t     w_nxt_ctl  [STAGES];
    logic [WIDTH-1:0]  w_nxt_data [STAGES];
    logic [CW-1:0]     w_sum      [STAGES];
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_szero;
    logic [STAGES:0]   w_ready;
    logic [WIDTH-1:0]  w_y_eff;
    logic              w_flush;
    logic              w_unused;

    assign w_y_eff = sub ? ~y : y;

`ifdef YSYX_220053_ADDSUB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = !r_ctl[k].valid || w_ready[k+1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_src_ctl[gi]  = '{valid: in_valid, sub: sub, carry: sub, zero: 1'b1,
                                      x_sign: x[WIDTH-1], y_sign: w_y_eff[WIDTH-1], ovf: 1'b0};
            assign w_src_data[gi] = x;
            assign w_src_y[gi]    = w_y_eff;
            assign w_src_tag[gi]  = in_tag;
        end else begin : g_body
            assign w_src_ctl[gi]  = r_ctl[gi-1];
            assign w_src_data[gi] = r_data[gi-1];
            assign w_src_y[gi]    = r_y[gi-1];
            assign w_src_tag[gi]  = r_tag[gi-1];
        end

        ysyx_220053_cla_slice #(.CW(CW)) u_cla (
            .a    (w_src_data[gi][gi*CW +: CW]),
            .b    (w_src_y[gi][gi*CW +: CW]),
            .cin  (w_src_ctl[gi].carry),
            .s    (w_sum[gi]),
            .cout (w_cout[gi]),
            .zero (w_szero[gi])
        );

        // ovf is only meaningful in the last stage, where the slice top bit is the MSB.
        assign w_nxt_ctl[gi] = '{valid:  w_src_ctl[gi].valid,
                                 sub:    w_src_ctl[gi].sub,
                                 carry:  w_cout[gi],
                                 zero:   w_src_ctl[gi].zero & w_szero[gi],
                                 x_sign: w_src_ctl[gi].x_sign,
                                 y_sign: w_src_ctl[gi].y_sign,
                                 ovf:    (w_src_ctl[gi].x_sign == w_src_ctl[gi].y_sign) &&
                                         (w_sum[gi][CW-1] != w_src_ctl[gi].x_sign)};

        assign w_nxt_data[gi] = (w_src_data[gi] & ~(WIDTH'({CW{1'b1}}) << (gi * CW)))
                              | (WIDTH'(w_sum[gi]) << (gi * CW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k]  <= '0;
                r_data[k] <= '0;
                r_y[k]    <= '0;
                r_tag[k]  <= '0;
            end
        end else if (w_flush) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k].valid <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    if (w_src_ctl[k].valid) begin
                        r_ctl[k]  <= w_nxt_ctl[k];
                        r_data[k] <= w_nxt_data[k];
                        r_y[k]    <= w_src_y[k];
                        r_tag[k]  <= w_src_tag[k];
                    end else begin
                        r_ctl[k].valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_ctl[STAGES-1].valid;
    assign result    = r_data[STAGES-1];
    assign cout      = r_ctl[STAGES-1].carry;
    assign overflow  = r_ctl[STAGES-1].ovf;
    assign zero      = r_ctl[STAGES-1].zero;
    assign out_tag   = r_tag[STAGES-1];

    assign w_unused = ^{r_y[STAGES-1], r_ctl[STAGES-1].sub,
                        r_ctl[STAGES-1].x_sign, r_ctl[STAGES-1].y_sign};

endmodule

// File: tb/tb_ysyx_220053_pipe_addsub.sv
// Directed and streaming checks for ysyx_220053_pipe_addsub at WIDTH=64, STAGES=4.
// Flush scenario is compiled in when YSYX_220053_ADDSUB_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_ysyx_220053_pipe_addsub;

    localparam int W  = 64;
    localparam int TW = 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          cout;
    logic          overflow;
    logic          zero;
    logic [TW-1:0] out_tag;
`ifdef YSYX_220053_ADDSUB_FLUSH_EN
    logic          flush;
`endif

    int n_checks;
    int n_fail;

    ysyx_220053_pipe_addsub #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef YSYX_220053_ADDSUB_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic          sub;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          c;
        logic          v;
        logic          z;
    } vec_t;

    typedef struct {
        logic [W-1:0]  res;
        logic          c;
        logic          v;
        logic          z;
        logic [TW-1:0] tag;
    } exp_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic [TW-1:0] t);
        exp_t e;
        logic [W:0]   full;
        logic [W-1:0] be;
        be    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, be} + (W+1)'(s);
        e.res = full[W-1:0];
        e.c   = full[W];
        e.v   = (a[W-1] == be[W-1]) && (e.res[W-1] != a[W-1]);
        e.z   = (e.res == '0);
        e.tag = t;
        return e;
    endfunction

    // One operation into an idle pipe; expects the result exactly 4 clocks later.
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        bit seen;
        @(negedge clk);
        x = v.x; y = v.y; sub = v.sub; in_tag = v.tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        $display("%s: tag=%0d result=0x%h cout=%b ovf=%b zero=%b latency=%0d",
                 nm, out_tag, result, cout, overflow, zero, lat);
        check({nm, ".latency"}, W'(lat), W'(4));
        check({nm, ".result"},  result, v.res);
        check({nm, ".cout"},    W'(cout), W'(v.c));
        check({nm, ".overflow"}, W'(overflow), W'(v.v));
        check({nm, ".zero"},    W'(zero), W'(v.z));
        check({nm, ".tag"},     W'(out_tag), W'(v.tag));
    endtask

    // Streams n random ops; rnd_ready toggles out_ready, otherwise it is held high
    // and each result must land exactly 4 iterations after its issue.
    task automatic run_stream(input int n, input bit rnd_ready, input int tag_base);
        exp_t          q[$];
        exp_t          e;
        int            sent;
        int            got;
        int            iter;
        bit            have;
        bit            stall;
        logic [W-1:0]  cx, cy, snap_res;
        logic          cs;
        logic [TW-1:0] snap_tag;
        sent = 0; got = 0; iter = 0; have = 1'b0; stall = 1'b0;
        cx = '0; cy = '0; cs = 1'b0; snap_res = '0; snap_tag = '0;
        while ((sent < n || got < n) && iter < 500) begin
            @(negedge clk);
            if (stall) begin
                check("stream.hold_valid",  W'(out_valid), W'(1));
                check("stream.hold_result", result, snap_res);
                check("stream.hold_tag",    W'(out_tag), W'(snap_tag));
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n) begin
                if (!have) begin
                    cx   = {$urandom(), $urandom()};
                    cy   = {$urandom(), $urandom()};
                    cs   = 1'($urandom_range(0, 1));
                    have = 1'b1;
                end
                in_valid = 1'b1; x = cx; y = cy; sub = cs; in_tag = TW'(tag_base + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream.unexpected_output", W'(1), W'(0));
                end else begin
                    e = q.pop_front();
                    $display("stream: tag=%0d result=0x%h cout=%b ovf=%b zero=%b",
                             out_tag, result, cout, overflow, zero);
                    check("stream.result",   result, e.res);
                    check("stream.cout",     W'(cout), W'(e.c));
                    check("stream.overflow", W'(overflow), W'(e.v));
                    check("stream.zero",     W'(zero), W'(e.z));
                    check("stream.tag",      W'(out_tag), W'(e.tag));
                    if (!rnd_ready) check("stream.timing", W'(iter), W'(got + 4));
                end
                got++;
            end
            stall    = out_valid && !out_ready;
            snap_res = result;
            snap_tag = out_tag;
            if (in_valid && in_ready) begin
                q.push_back(model(x, y, sub, in_tag));
                sent++;
                have = 1'b0;
            end
            iter++;
        end
        in_valid = 1'b0;
        check("stream.sent",     W'(sent), W'(n));
        check("stream.received", W'(got),  W'(n));
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; sub = 1'b0; in_tag = '0;
`ifdef YSYX_220053_ADDSUB_FLUSH_EN
        flush = 1'b0;
`endif
        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5'd1,  64'h0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{64'h5, 64'h7, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5'd3, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 5'd4, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{64'h7, 64'h7, 1'b1, 5'd5, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 5'd6, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 5'd7,
                     64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 5'd8, 64'h0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{64'h0, 64'h0, 1'b1, 5'd9, 64'h0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5'd10,
                     64'h0246_8ACF_1357_9BCF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd11,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd12,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0};

        // Power-on reset
        #1 rst_n = 1'b0;
        #2;
        check("reset.out_valid", W'(out_valid), W'(0));
        check("reset.result",    result, W'(0));
        check("reset.cout",      W'(cout), W'(0));
        check("reset.overflow",  W'(overflow), W'(0));
        check("reset.zero",      W'(zero), W'(0));
        check("reset.out_tag",   W'(out_tag), W'(0));
        check("reset.in_ready",  W'(in_ready), W'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        run_stream(16, 1'b1, 0);
        run_stream(8, 1'b0, 16);

        // Asynchronous reset with three ops held in flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 64'h0123_4567_89AB_CDEF + 64'(i); y = 64'h1; sub = 1'b0;
            in_tag = TW'(20 + i); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid.pre_valid", W'(out_valid), W'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        $display("rst_mid: out_valid=%b result=0x%h tag=%0d", out_valid, result, out_tag);
        check("rst_mid.out_valid", W'(out_valid), W'(0));
        check("rst_mid.result",    result, W'(0));
        check("rst_mid.cout",      W'(cout), W'(0));
        check("rst_mid.overflow",  W'(overflow), W'(0));
        check("rst_mid.zero",      W'(zero), W'(0));
        check("rst_mid.out_tag",   W'(out_tag), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid.in_ready_after", W'(in_ready), W'(1));
        check("rst_mid.discarded",      W'(out_valid), W'(0));
        run_vec(vecs[1], "rst_mid.next");

`ifdef YSYX_220053_ADDSUB_FLUSH_EN
        begin
            int leaked;
            @(negedge clk);
            out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                x = 64'(i); y = 64'h1; sub = 1'b0; in_tag = TW'(24 + i); in_valid = 1'b1;
                @(negedge clk);
            end
            x = 64'h55; in_tag = TW'(28); in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b0;
            $display("flush: out_valid=%b", out_valid);
            check("flush.out_valid", W'(out_valid), W'(0));
            leaked = 0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid) leaked++;
            end
            check("flush.leaked_ops", W'(leaked), W'(0));
            run_vec(vecs[9], "flush.next");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_pipe_addsub.md
Name: ysyx_220053_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake. It is the next-generation integer adder for the npc core.
- The WIDTH-bit operation is split into STAGES equal slices. Slice k resolves in pipeline stage k, and its carry is registered into stage k+1.
- Provides carry, signed overflow and zero flags plus a pass-through tag. Serves the ALU and the multi-cycle mul/div datapath at WIDTH=64 without a long carry path in one cycle.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..8); slice width CW = WIDTH/STAGES.
- TAG_W, 5, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage 0 can accept.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- sub  in  1  1 = x - y, 0 = x + y.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  sum/difference modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Operand conditioning: y_eff = sub ? ~y : y; carry-in to slice 0 = sub.
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- Stage k register contents:
  - valid_k, tag, sub, MSB-sign info;
  - result slices 0..k computed so far;
  - unconsumed operand slices k+1..STAGES-1 (skewed);
  - registered carry c_{k+1};
  - running zero flag (AND of per-slice zero).
- Stage k computes slice k combinationally with the CW-bit CLA from the previous stage's carry, then registers the outcome.
- Advance rule: stage k loads when ready_k = !valid_k || ready_{k+1}, where ready_STAGES = out_ready and in_ready = ready_0.
- Fully registered output. Latency is exactly STAGES cycles from input transfer to out_valid with no stalls. Throughput is 1 op/cycle while out_ready=1.
- Backpressure: with out_ready=0, stages hold their contents and bubbles collapse. No operation is lost, duplicated or reordered.
- Final stage outputs:
  - cout = carry out of MSB.
  - overflow = (x[W-1] == y_eff[W-1]) && (result[W-1] != x[W-1]).
  - zero = AND of slice zeros.
- Outputs are stable while out_valid && !out_ready.
- Reset (asynchronous, any time, including mid-operation):
  - all valid_k = 0, so out_valid = 0;
  - result/cout/overflow/zero/out_tag = 0;
  - in_ready = 1 from the first edge after release; in-flight ops are discarded.
- Simultaneous in-transfer and out-transfer with a full pipeline is legal and keeps the pipeline full.
- STAGES=1 degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro: YSYX_220053_ADDSUB_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 at a rising edge clears all valid_k; out_valid=0 the next cycle.
  - An input presented in the same cycle as flush is dropped.
  - in_ready is still computed normally.
- Undefined: no flush port; the pipeline drains only by handshake.

Decomposition:
- Shared package ysyx_220053_alu_pkg holds:
  - default constants ADDSUB_WIDTH=64, ADDSUB_STAGES=4, ADDSUB_TAG_W=5;
  - localparam helper CW = WIDTH/STAGES;
  - packed struct typedef of a stage register (valid, tag, sub, carry, zero, sign bits).
- One sub-module, ysyx_220053_cla_slice (parameter CW):
  - inputs a, b, cin;
  - outputs s, cout, slice-zero;
  - group generate/propagate lookahead;
  - instantiated STAGES times in a generate loop.

Test Plan (WIDTH=64, STAGES=4):
1. Carry/zero: add 0xFFFF_FFFF_FFFF_FFFF + 1, out_ready=1 -> 4 cycles later result=0, cout=1, zero=1, overflow=0, out_tag echoed.
2. Subtraction with borrow: sub 5 - 7 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0, zero=0.
3. Signed overflow: add 0x7FFF_FFFF_FFFF_FFFF + 1 -> result=0x8000_0000_0000_0000, overflow=1, cout=0. Also sub 0x8000_0000_0000_0000 - 1 -> overflow=1.
4. Streaming with backpressure:
   - 16 random back-to-back ops, out_ready toggled pseudo-randomly -> results match the reference model in order, tags 0..15, none lost or duplicated;
   - with out_ready held at 1, exactly 1 result per cycle after the 4-cycle fill.
5. Reset mid-flight: 3 ops in flight, assert rst_n=0 asynchronously -> out_valid=0 immediately, all outputs 0; after release in_ready=1 and the next op completes normally.
6. With YSYX_220053_ADDSUB_FLUSH_EN defined: flush with 4 ops in flight plus one offered -> out_valid=0 next cycle, no flushed tag ever appears, and a subsequent op has latency 4.
